// File: rtl/seq_detector_param.sv
// ----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial bit-sequence detector. Qualified serial bits are shifted
// into a LEN-bit window which is compared against a run-time reloadable
// pattern. A match is reported two ways:
//   - y_mealy : combinational flag in the cycle the final pattern bit is
//               presented.
//   - y       : registered one-cycle pulse on the following cycle.
// Matches are also tallied in a saturating counter. In non-overlapping mode
// the window fill restarts after every match, so the next match needs LEN
// fresh bits.
//
// Parameters:
//   LEN      pattern length in bits (2..16)
//   PATTERN  reset-time pattern, MSB is the first bit received
//   OVERLAP  1: match bits may be reused, 0: detection restarts after a match
//   CNT_W    width of the match counter
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   x          in   serial data bit
//   x_valid    in   qualifies x; a bit is consumed only when high
//   pat_load   in   load pat_in as the new pattern (clears history)
//   pat_in     in   [LEN]   pattern value for pat_load
//   y          out  registered match pulse
//   y_mealy    out  combinational match flag for the presented bit
//   match_cnt  out  [CNT_W] saturating match count
//   pattern    out  [LEN]   currently active pattern
// ----------------------------------------------------------------------------
module seq_detector_param #(
   parameter int unsigned          LEN     = 4,
   parameter logic [LEN-1:0]       PATTERN = 4'b1011,
   parameter bit                   OVERLAP = 1'b1,
   parameter int unsigned          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic             pat_load,
   input  logic [LEN-1:0]   pat_in,
   output logic             y,
   output logic             y_mealy,
   output logic [CNT_W-1:0] match_cnt,
   output logic [LEN-1:0]   pattern
);

   // fill must be able to represent 0..LEN inclusive
   localparam int unsigned    FILL_W   = $clog2(LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);
   // fill value at which the incoming bit completes a full window
   localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   logic [LEN-1:0]    sr_q, sr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [LEN-1:0]    pat_q, pat_d;
   logic              y_q, y_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [LEN-1:0]    sr_shift;
   logic              window_full;
   logic              match_hit;

   // ------------------------------------------------------------------------
   // Match evaluation on the window as it would look after taking x
   // ------------------------------------------------------------------------
   always_comb begin
      sr_shift    = {sr_q[LEN-2:0], x};
      window_full = (fill_q >= FILL_THR);
      match_hit   = x_valid && window_full && (sr_shift == pat_q);
      // reset and pat_load both discard the bit, so they mask the early flag
      y_mealy     = match_hit && !reset && !pat_load;
   end

   // ------------------------------------------------------------------------
   // Next-state logic (reset is applied in the register process)
   // ------------------------------------------------------------------------
   always_comb begin
      sr_d   = sr_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      y_d    = 1'b0;
      cnt_d  = cnt_q;

      if (pat_load) begin
         pat_d  = pat_in;
         sr_d   = '0;
         fill_d = '0;
      end else if (x_valid) begin
         sr_d   = sr_shift;
         fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
         if (match_hit) begin
            y_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (!OVERLAP) begin
               fill_d = '0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q   <= '0;
         fill_q <= '0;
         pat_q  <= PATTERN;
         y_q    <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sr_q   <= sr_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         y_q    <= y_d;
         cnt_q  <= cnt_d;
      end
   end

   assign y         = y_q;
   assign match_cnt = cnt_q;
   assign pattern   = pat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// ----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed testbench for seq_detector_param. Three instances share one
// stimulus stream:
//   dut_a : LEN=4, PATTERN=1011, OVERLAP=1, CNT_W=8
//   dut_b : LEN=4, PATTERN=1011, OVERLAP=0, CNT_W=8
//   dut_c : LEN=2, PATTERN=11,   OVERLAP=1, CNT_W=2
// Inputs change on the falling edge; y_mealy is sampled 1 ns later and the
// registered outputs 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       x = 1'b0;
   logic       x_valid = 1'b0;
   logic       pat_load = 1'b0;
   logic [3:0] pat_in = 4'b0000;

   logic       y_a, ym_a, y_b, ym_b, y_c, ym_c;
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;
   logic [3:0] pat_a, pat_b;
   logic [1:0] pat_c;

   // y_mealy values captured during the most recent step
   logic       m_a, m_b, m_c;

   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   seq_detector_param #(
      .LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)
   ) dut_a (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in), .y(y_a), .y_mealy(ym_a), .match_cnt(cnt_a), .pattern(pat_a)
   );

   seq_detector_param #(
      .LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)
   ) dut_b (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in), .y(y_b), .y_mealy(ym_b), .match_cnt(cnt_b), .pattern(pat_b)
   );

   seq_detector_param #(
      .LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)
   ) dut_c (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in[1:0]), .y(y_c), .y_mealy(ym_c), .match_cnt(cnt_c),
      .pattern(pat_c)
   );

   // One clock of stimulus: drive on negedge, capture mealy, advance past posedge.
   task automatic step(input logic v, input logic b, input logic ld,
                       input logic rst, input logic [3:0] pin);
      @(negedge clk);
      x_valid  = v;
      x        = b;
      pat_load = ld;
      reset    = rst;
      pat_in   = pin;
      #1;
      m_a = ym_a;
      m_b = ym_b;
      m_c = ym_c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (y_a !== 1'b0) begin n_err++; $display("FAIL reset_y got=%b exp=0", y_a); end
      n_cmp++;
      if (cnt_a !== 8'd0) begin n_err++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
      n_cmp++;
      if (pat_a !== 4'b1011) begin
         n_err++; $display("FAIL reset_pat_a got=%b exp=1011", pat_a);
      end
      n_cmp++;
      if (pat_c !== 2'b11) begin n_err++; $display("FAIL reset_pat_c got=%b exp=11", pat_c); end
      n_cmp++;
      if (cnt_c !== 2'd0) begin n_err++; $display("FAIL reset_cnt_c got=%0d exp=0", cnt_c); end
   endtask

   // Stream 1,0,1,1,0,1,1 : overlap matches at bits 4 and 7, non-overlap at 4 only.
   task automatic test_overlap();
      logic [6:0] stream;
      logic [6:0] exp_a;
      logic [6:0] exp_b;
      stream = 7'b1011011;
      exp_a  = 7'b0001001;
      exp_b  = 7'b0001000;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b1, stream[6-i], 1'b0, 1'b0, 4'b0000);
         n_cmp++;
         if (m_a !== exp_a[6-i]) begin
            n_err++; $display("FAIL ovl_mealy_a bit=%0d got=%b exp=%b", i + 1, m_a, exp_a[6-i]);
         end
         n_cmp++;
         if (y_a !== exp_a[6-i]) begin
            n_err++; $display("FAIL ovl_y_a bit=%0d got=%b exp=%b", i + 1, y_a, exp_a[6-i]);
         end
         n_cmp++;
         if (y_b !== exp_b[6-i]) begin
            n_err++; $display("FAIL novl_y_b bit=%0d got=%b exp=%b", i + 1, y_b, exp_b[6-i]);
         end
         n_cmp++;
         if (m_b !== exp_b[6-i]) begin
            n_err++; $display("FAIL novl_mealy_b bit=%0d got=%b exp=%b", i + 1, m_b, exp_b[6-i]);
         end
      end
      n_cmp++;
      if (cnt_a !== 8'd2) begin n_err++; $display("FAIL ovl_cnt_a got=%0d exp=2", cnt_a); end
      n_cmp++;
      if (cnt_b !== 8'd1) begin n_err++; $display("FAIL novl_cnt_b got=%0d exp=1", cnt_b); end
   endtask

   // 1,0,1,1 with three idle cycles after each bit: one pulse after the last bit.
   task automatic test_gaps();
      logic [3:0] stream;
      int pulses;
      stream = 4'b1011;
      pulses = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, stream[3-i], 1'b0, 1'b0, 4'b0000);
         n_cmp++;
         if (y_a !== (i == 3)) begin
            n_err++; $display("FAIL gap_y bit=%0d got=%b exp=%b", i + 1, y_a, (i == 3));
         end
         if (y_a === 1'b1) pulses++;
         for (int g = 0; g < 3; g++) begin
            // x toggled during gaps to show it is ignored when not valid
            step(1'b0, ~stream[3-i], 1'b0, 1'b0, 4'b0000);
            n_cmp++;
            if (y_a !== 1'b0 || m_a !== 1'b0) begin
               n_err++; $display("FAIL gap_idle bit=%0d gap=%0d y=%b mealy=%b exp=0/0",
                                 i + 1, g, y_a, m_a);
            end
            if (y_a === 1'b1) pulses++;
         end
      end
      n_cmp++;
      if (pulses !== 1) begin n_err++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
      n_cmp++;
      if (cnt_a !== 8'd1) begin n_err++; $display("FAIL gap_cnt got=%0d exp=1", cnt_a); end
   endtask

   // 1,0,1, load 0110 (with x=1 valid, ignored), 1,1,0 -> nothing; 0,1,1,0 -> match.
   task automatic test_pat_load();
      logic [6:0] stream;
      logic [6:0] exp_y;
      logic [2:0] pre;
      stream = 7'b1100110;
      exp_y  = 7'b0000001;
      pre    = 3'b101;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, pre[2-i], 1'b0, 1'b0, 4'b0000);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
      n_cmp++;
      if (m_a !== 1'b0 || y_a !== 1'b0) begin
         n_err++; $display("FAIL load_cycle mealy=%b y=%b exp=0/0", m_a, y_a);
      end
      n_cmp++;
      if (pat_a !== 4'b0110) begin n_err++; $display("FAIL load_pat got=%b exp=0110", pat_a); end
      for (int i = 0; i < 7; i++) begin
         step(1'b1, stream[6-i], 1'b0, 1'b0, 4'b0000);
         n_cmp++;
         if (y_a !== exp_y[6-i] || m_a !== exp_y[6-i]) begin
            n_err++; $display("FAIL load_stream bit=%0d y=%b mealy=%b exp=%b",
                              i + 1, y_a, m_a, exp_y[6-i]);
         end
      end
      n_cmp++;
      if (cnt_a !== 8'd1) begin n_err++; $display("FAIL load_cnt got=%0d exp=1", cnt_a); end
      n_cmp++;
      if (pat_a !== 4'b0110) begin
         n_err++; $display("FAIL load_pat_hold got=%b exp=0110", pat_a);
      end
   endtask

   // pat_load coinciding with the final pattern bit: no match, no count.
   task automatic test_load_collision();
      logic [2:0] pre;
      pre = 3'b101;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, pre[2-i], 1'b0, 1'b0, 4'b0000);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b1011);
      n_cmp++;
      if (m_a !== 1'b0 || y_a !== 1'b0 || cnt_a !== 8'd0) begin
         n_err++; $display("FAIL load_collide mealy=%b y=%b cnt=%0d exp=0/0/0", m_a, y_a, cnt_a);
      end
   endtask

   // LEN=2, pattern 11, six 1s: five consecutive pulses, counter saturates at 3.
   task automatic test_saturate();
      logic [1:0] exp_cnt;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
         exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
         n_cmp++;
         if (y_c !== (i != 0) || m_c !== (i != 0)) begin
            n_err++; $display("FAIL sat_y bit=%0d y=%b mealy=%b exp=%b", i + 1, y_c, m_c, (i != 0));
         end
         n_cmp++;
         if (cnt_c !== exp_cnt) begin
            n_err++; $display("FAIL sat_cnt bit=%0d got=%0d exp=%0d", i + 1, cnt_c, exp_cnt);
         end
      end
   endtask

   // 1,0,1, reset (with x=1 valid), 1 -> nothing; then 1,0,1,1 -> one pulse.
   task automatic test_reset_mid();
      logic [2:0] pre;
      logic [3:0] post;
      pre  = 3'b101;
      post = 4'b1011;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, pre[2-i], 1'b0, 1'b0, 4'b0000);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
      n_cmp++;
      if (m_a !== 1'b0 || y_a !== 1'b0) begin
         n_err++; $display("FAIL rst_collide mealy=%b y=%b exp=0/0", m_a, y_a);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      n_cmp++;
      if (y_a !== 1'b0 || cnt_a !== 8'd0 || pat_a !== 4'b1011) begin
         n_err++; $display("FAIL rst_after y=%b cnt=%0d pat=%b exp=0/0/1011", y_a, cnt_a, pat_a);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, post[3-i], 1'b0, 1'b0, 4'b0000);
         n_cmp++;
         if (y_a !== (i == 3)) begin
            n_err++; $display("FAIL rst_stream bit=%0d got=%b exp=%b", i + 1, y_a, (i == 3));
         end
      end
      n_cmp++;
      if (cnt_a !== 8'd1) begin n_err++; $display("FAIL rst_cnt got=%0d exp=1", cnt_a); end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_gaps();
      test_pat_load();
      test_load_collision();
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
